counter_sequencer: RTL and testbench

Programmable controller that sequences a free-running up-counter datapath into a timer.
- Software loads a terminal count and a prescale value over a valid/ready config handshake, then starts, pauses or stops the count.
- The block emits a one-cycle terminal-count pulse and runs in one-shot or periodic (auto-reload) mode.
- Sits between the control/register block and any logic that needs timed events.

---
 rtl/counter_sequencer_pkg.sv | 11 +
 rtl/counter_sequencer_if.sv | 30 +++
 rtl/counter_sequencer_tick.sv | 25 ++
 rtl/counter_sequencer.sv | 88 ++++++++
 tb/tb_counter_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared state encoding and default widths for the counter sequencer
package counter_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } seq_state_t;
    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 4;
endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: config handshake, control strobes and status outputs of the sequencer
interface counter_sequencer_if
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_limit;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_periodic;
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tc_pulse;
    logic                  done;

    modport master (
        output cfg_valid, cfg_limit, cfg_prescale, cfg_periodic, start, stop, pause,
        input  cfg_ready, count, busy, tc_pulse, done
    );

    modport slave (
        input  cfg_valid, cfg_limit, cfg_prescale, cfg_periodic, start, stop, pause,
        output cfg_ready, count, busy, tc_pulse, done
    );
endinterface

// File: rtl/counter_sequencer_tick.sv
// prescale_tick_gen: divides the clock, ticking on the cycle its counter equals prescale
module prescale_tick_gen #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // clear wins over enable; a tick folds the counter back to zero
    always_comb begin
        tick  = en && (cnt_q == prescale);
        cnt_d = clr ? '0 : (tick ? '0 : (en ? cnt_q + 1'b1 : cnt_q));
    end

    // prescale counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable one-shot/periodic timer built from an up-counter and a prescaler
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic clk,
    input  logic rst,
    counter_sequencer_if.slave bus_if
);
    seq_state_t            state_q;
    logic [WIDTH-1:0]      count_q;
    logic [WIDTH-1:0]      limit_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  periodic_q;
    logic                  tc_q;
    logic                  tick;
    logic                  tick_clr;
    logic                  tick_en;
    logic                  idle_or_done;

    // prescaler only runs while counting unpaused; it is held at zero outside RUN/PAUSE
    always_comb begin
        idle_or_done = (state_q == IDLE) || (state_q == DONE);
        tick_clr     = bus_if.stop || idle_or_done;
        tick_en      = (state_q == RUN) && !bus_if.stop && !bus_if.pause;
    end

    prescale_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (tick_clr),
        .en       (tick_en),
        .prescale (presc_q),
        .tick     (tick)
    );

    // sequencer FSM with config latch, count datapath and registered terminal-count pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= '0;
            presc_q    <= '0;
            periodic_q <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus_if.stop) begin
                state_q <= IDLE;
                count_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (bus_if.cfg_valid) begin
                            limit_q    <= bus_if.cfg_limit;
                            presc_q    <= bus_if.cfg_prescale;
                            periodic_q <= bus_if.cfg_periodic;
                        end
                        if (bus_if.start || bus_if.cfg_valid) begin
                            state_q <= bus_if.start ? RUN : IDLE;
                            count_q <= '0;
                        end
                    end
                    RUN: begin
                        if (bus_if.pause) state_q <= PAUSE;
                        else if (tick) begin
                            if (count_q == limit_q) begin
                                tc_q <= 1'b1;
                                if (periodic_q) count_q <= '0;
                                else            state_q <= DONE;
                            end else count_q <= count_q + 1'b1;
                        end
                    end
                    PAUSE: if (!bus_if.pause) state_q <= RUN;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus_if.count     = count_q;
    assign bus_if.tc_pulse  = tc_q;
    assign bus_if.busy      = (state_q == RUN) || (state_q == PAUSE);
    assign bus_if.done      = (state_q == DONE);
    assign bus_if.cfg_ready = idle_or_done;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: randomized and directed checks of the sequencer against an elapsed-time model
module tb_counter_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    counter_sequencer_if #(.WIDTH(4), .PRESCALE_W(4)) bus ();

    counter_sequencer #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 counting, 2 paused, 3 finished; count derived from elapsed active cycles
    int m_mode = 0, m_elapsed = 0, m_lim = 0, m_pre = 0;
    bit m_per = 0, m_tc = 0;

    function automatic int exp_count();
        return (m_mode == 3) ? m_lim : (m_elapsed / (m_pre + 1)) % (m_lim + 1);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic go(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cfg(int l, int p, bit per);
        bus.cfg_limit    = l[3:0];
        bus.cfg_prescale = p[3:0];
        bus.cfg_periodic = per;
        bus.cfg_valid    = 1'b1;
        go(1);
        bus.cfg_valid    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        go(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        go(1);
        bus.stop = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_elapsed = 0; m_lim = 0; m_pre = 0; m_per = 0; m_tc = 0;
            end else if (bus.stop) begin
                m_mode = 0; m_elapsed = 0; m_tc = 0;
            end else if (m_mode == 0 || m_mode == 3) begin
                m_tc = 0;
                if (bus.cfg_valid) begin
                    m_lim = int'(bus.cfg_limit);
                    m_pre = int'(bus.cfg_prescale);
                    m_per = bus.cfg_periodic;
                end
                if (bus.start || bus.cfg_valid) begin
                    m_mode    = bus.start ? 1 : 0;
                    m_elapsed = 0;
                end
            end else if (m_mode == 1) begin
                if (bus.pause) begin
                    m_mode = 2;
                    m_tc   = 0;
                end else begin
                    m_elapsed++;
                    m_tc = (m_elapsed % ((m_lim + 1) * (m_pre + 1))) == 0;
                    if (m_tc && !m_per) m_mode = 3;
                end
            end else begin
                m_tc = 0;
                if (!bus.pause) m_mode = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("model_count", int'(bus.count), exp_count());
                chk("model_tc", int'(bus.tc_pulse), int'(m_tc));
                chk("model_busy", int'(bus.busy), int'(m_mode == 1 || m_mode == 2));
                chk("model_done", int'(bus.done), int'(m_mode == 3));
                chk("model_ready", int'(bus.cfg_ready), int'(m_mode == 0 || m_mode == 3));
            end
        end
    end

    initial begin
        int first, second, n;
        bus.cfg_valid = 0; bus.cfg_limit = 0; bus.cfg_prescale = 0; bus.cfg_periodic = 0;
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        go(2);
        rst = 1'b0;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_ready", int'(bus.cfg_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_tc", int'(bus.tc_pulse), 0);
        go(1);

        cfg(5, 0, 0);
        pulse_start();
        for (int i = 0; i <= 5; i++) begin
            chk("oneshot_count", int'(bus.count), i);
            chk("oneshot_tc_low", int'(bus.tc_pulse), 0);
            go(1);
        end
        chk("oneshot_tc", int'(bus.tc_pulse), 1);
        chk("oneshot_done", int'(bus.done), 1);
        chk("oneshot_busy", int'(bus.busy), 0);
        chk("oneshot_hold", int'(bus.count), 5);
        go(1);
        chk("oneshot_tc_once", int'(bus.tc_pulse), 0);
        chk("oneshot_hold2", int'(bus.count), 5);

        cfg(3, 2, 1);
        pulse_start();
        first = -1; second = -1;
        for (n = 0; n < 40; n++) begin
            if (bus.tc_pulse) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            go(1);
        end
        chk("periodic_first_tc", first, 12);
        chk("periodic_second_tc", second, 24);
        chk("periodic_busy", int'(bus.busy), 1);
        pulse_stop();

        cfg(15, 0, 1);
        pulse_start();
        go(7);
        chk("pause_at", int'(bus.count), 7);
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go(1);
            chk("pause_hold", int'(bus.count), 7);
            chk("pause_no_tc", int'(bus.tc_pulse), 0);
        end
        bus.pause = 1'b0;
        go(2);
        chk("pause_resume", int'(bus.count), 8);
        pulse_stop();

        cfg(2, 0, 0);
        pulse_start();
        go(2);
        chk("stop_tc_at", int'(bus.count), 2);
        pulse_stop();
        chk("stop_tc", int'(bus.tc_pulse), 0);
        chk("stop_count", int'(bus.count), 0);
        chk("stop_done", int'(bus.done), 0);
        chk("stop_ready", int'(bus.cfg_ready), 1);

        cfg(3, 0, 0);
        pulse_start();
        bus.cfg_limit = 4'd9;
        bus.cfg_valid = 1'b1;
        chk("busy_ready", int'(bus.cfg_ready), 0);
        go(2);
        chk("busy_ready2", int'(bus.cfg_ready), 0);
        bus.cfg_valid = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin
            go(1);
            n++;
        end
        chk("busy_done_timeout", int'(n < 20), 1);
        chk("busy_old_limit", int'(bus.count), 3);
        bus.cfg_limit = 4'd1; bus.cfg_prescale = 4'd0; bus.cfg_periodic = 1'b0;
        bus.cfg_valid = 1'b1; bus.start = 1'b1;
        go(1);
        bus.cfg_valid = 1'b0; bus.start = 1'b0;
        chk("combo_count0", int'(bus.count), 0);
        chk("combo_busy", int'(bus.busy), 1);
        go(1);
        chk("combo_count1", int'(bus.count), 1);
        go(1);
        chk("combo_done", int'(bus.done), 1);
        chk("combo_tc", int'(bus.tc_pulse), 1);
        chk("combo_hold", int'(bus.count), 1);

        cfg(10, 1, 1);
        pulse_start();
        go(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", int'(bus.count), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_ready", int'(bus.cfg_ready), 1);
        go(1);
        rst = 1'b0;
        go(1);

        for (int i = 0; i < 400; i++) begin
            bus.cfg_valid    = ($urandom_range(0, 3) == 0);
            bus.cfg_limit    = 4'($urandom_range(0, 15));
            bus.cfg_prescale = 4'($urandom_range(0, 3));
            bus.cfg_periodic = 1'($urandom_range(0, 1));
            bus.start        = ($urandom_range(0, 5) == 0);
            bus.stop         = ($urandom_range(0, 40) == 0);
            bus.pause        = ($urandom_range(0, 7) == 0);
            go(1);
        end
        bus.cfg_valid = 0; bus.start = 0; bus.stop = 0; bus.pause = 0;
        cfg(15, 0, 1);
        pulse_start();
        go(40);
        pulse_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
